// File: rtl/sdram_write.sv
// Write-burst engine: requests the bus, then issues ACTIVE, WRITE with BURST_LEN
// data beats, and an all-bank PRECHARGE before handing the bus back to the arbiter.
module sdram_write #(
  parameter int BURST_LEN = 4,
  parameter int TRCD_CYC  = 2,
  parameter int TWR_CYC   = 2,
  parameter int TRP_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done_flag,
  input  logic        wr_trig,
  input  logic [23:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_data_ack,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_en,
  output logic        sdram_wr_done,
  output logic        wr_busy,
  output logic [3:0]  sdram_cmds,
  output logic [12:0] sdram_addrs,
  output logic [1:0]  sdram_bs,
  output logic [15:0] sdram_dq,
  output logic        sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_REQ   = 4'd1;
  localparam logic [3:0] S_ACT   = 4'd2;
  localparam logic [3:0] S_TRCD  = 4'd3;
  localparam logic [3:0] S_WR    = 4'd4;
  localparam logic [3:0] S_BURST = 4'd5;
  localparam logic [3:0] S_TWR   = 4'd6;
  localparam logic [3:0] S_PRE   = 4'd7;
  localparam logic [3:0] S_TRP   = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  localparam logic [8:0] BEAT_LAST = 9'(BURST_LEN - 1);
  localparam logic [7:0] TRCD_LOAD = 8'(TRCD_CYC - 1);
  localparam logic [7:0] TWR_LOAD  = 8'(TWR_CYC - 1);
  localparam logic [7:0] TRP_LOAD  = 8'(TRP_CYC - 1);

  logic [3:0]  r_state;
  logic [23:0] r_addr;
  logic [8:0]  r_beat;
  logic [7:0]  r_wait;
  logic [3:0]  r_cmds;
  logic [12:0] r_addrs;
  logic [1:0]  r_bs;
  logic [15:0] r_dq;
  logic        r_oe;
  logic        r_ack;
  logic        r_req;
  logic        r_done;
  logic        r_busy;

  logic [1:0]  w_bank;
  logic [12:0] w_row;
  logic [8:0]  w_col;

  assign w_bank = r_addr[23:22];
  assign w_row  = r_addr[21:9];
  assign w_col  = r_addr[8:0];

  // Every output is set one edge ahead, so each state decides the next cycle's bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_cmds  <= CMD_NOP;
      r_addrs <= '0;
      r_bs    <= '0;
      r_dq    <= '0;
      r_oe    <= 1'b0;
      r_ack   <= 1'b0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cmds  <= CMD_NOP;
      r_addrs <= '0;
      r_bs    <= w_bank;
      r_dq    <= '0;
      r_oe    <= 1'b0;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bs   <= '0;
          r_busy <= 1'b0;
          if (wr_trig && sdram_init_done_flag) begin
            r_addr  <= wr_addr;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_bs <= '0;
          if (sdram_wr_en) begin
            r_req   <= 1'b0;
            r_state <= S_ACT;
          end
        end
        S_ACT: begin
          r_cmds  <= CMD_ACT;
          r_addrs <= w_row;
          r_wait  <= TRCD_LOAD;
          // The first word must be requested one cycle before the WRITE command.
          if (TRCD_CYC == 1) begin
            r_ack   <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_state <= S_TRCD;
          end
        end
        S_TRCD: begin
          r_wait <= r_wait - 8'd1;
          if (r_wait == 8'd1) begin
            r_ack   <= 1'b1;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          r_cmds  <= CMD_WRITE;
          r_addrs <= {4'b0000, w_col};
          r_dq    <= wr_data;
          r_oe    <= 1'b1;
          r_beat  <= BEAT_LAST;
          r_wait  <= TWR_LOAD;
          if (BURST_LEN > 1) begin
            r_ack   <= 1'b1;
            r_state <= S_BURST;
          end else begin
            r_state <= (TWR_CYC == 1) ? S_PRE : S_TWR;
          end
        end
        S_BURST: begin
          r_dq   <= wr_data;
          r_oe   <= 1'b1;
          r_beat <= r_beat - 9'd1;
          r_ack  <= (r_beat >= 9'd2);
          if (r_beat == 9'd1) begin
            r_wait  <= TWR_LOAD;
            r_state <= (TWR_CYC == 1) ? S_PRE : S_TWR;
          end
        end
        S_TWR: begin
          r_wait <= r_wait - 8'd1;
          if (r_wait == 8'd1) r_state <= S_PRE;
        end
        S_PRE: begin
          r_cmds  <= CMD_PRE;
          r_addrs <= 13'h0400;
          r_wait  <= TRP_LOAD;
          r_state <= (TRP_CYC == 1) ? S_DONE : S_TRP;
        end
        S_TRP: begin
          r_wait <= r_wait - 8'd1;
          if (r_wait == 8'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_data_ack   = r_ack;
  assign sdram_wr_req  = r_req;
  assign sdram_wr_done = r_done;
  assign wr_busy       = r_busy;
  assign sdram_cmds    = r_cmds;
  assign sdram_addrs   = r_addrs;
  assign sdram_bs      = r_bs;
  assign sdram_dq      = r_dq;
  assign sdram_dq_oe   = r_oe;

endmodule
